// File: rtl/pc_seq_pkg.sv
// Shared encodings for the stack processor PC/return-stack sequencer:
// opcodes, datapath select values, FSM states and decoded opcode classes.
package pc_seq_pkg;

    localparam logic [3:0] OP_JUMP = 4'h1;
    localparam logic [3:0] OP_CALL = 4'h2;
    localparam logic [3:0] OP_RET  = 4'h3;
    localparam logic [3:0] OP_BZ   = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] PCC_RSTACK = 3'd0;
    localparam logic [2:0] PCC_JUMP   = 3'd1;
    localparam logic [2:0] PCC_BRANCH = 3'd2;
    localparam logic [2:0] PCC_INC    = 3'd4;

    localparam logic [1:0] RS_NOP  = 2'd0;
    localparam logic [1:0] RS_PUSH = 2'd1;
    localparam logic [1:0] RS_POP  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_t;

    typedef enum logic [2:0] {
        C_SEQ,
        C_JUMP,
        C_CALL,
        C_RET,
        C_BZ,
        C_HALT
    } op_class_t;

endpackage

// File: rtl/pc_seq_decode.sv
// Combinational opcode classifier: IR[15:12] to sequencer opcode class.
module pc_seq_decode
    import pc_seq_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = C_SEQ;
        case (opcode)
            OP_JUMP: op_class = C_JUMP;
            OP_CALL: op_class = C_CALL;
            OP_RET:  op_class = C_RET;
            OP_BZ:   op_class = C_BZ;
            OP_HALT: op_class = C_HALT;
            default: op_class = C_SEQ;
        endcase
    end

endmodule

// File: rtl/pc_sequencer_ctrl.sv
// Multicycle fetch/decode/execute controller for the PC and return-stack
// datapath; all outputs are Moore, decoded from state, opcode and take.
module pc_sequencer_ctrl
    import pc_seq_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Run,
    input  logic [15:0]      inst,
    input  logic             Zero,
    input  logic             Overflow,
    output logic             PCWrite,
    output logic [2:0]       PCControl,
    output logic [1:0]       RStackOP,
    output logic             IRWrite,
    output logic             Halted,
    output logic             Fault,
    output logic [CNT_W-1:0] InstCount
);

    state_t          state, next_state;
    op_class_t       op_class;
    logic [3:0]      ir_op;
    logic            take;
    logic            cnt_inc;
    logic [CNT_W-1:0] count;

    // Only the opcode field steers control; operand bits belong to the datapath.
    logic unused_inst_bits;
    assign unused_inst_bits = ^inst[11:0];

    pc_seq_decode u_decode (
        .opcode   (ir_op),
        .op_class (op_class)
    );

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state <= S_IDLE;
            ir_op <= '0;
            take  <= 1'b0;
            count <= '0;
        end else begin
            state <= next_state;
            if (state == S_FETCH)
                ir_op <= inst[15:12];
            if (state == S_DECODE)
                take <= Zero;
            if (cnt_inc)
                count <= count + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        cnt_inc    = 1'b0;
        case (state)
            S_IDLE:   if (Run) next_state = S_FETCH;
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                if (op_class == C_HALT) begin
                    next_state = S_HALT;
                    cnt_inc    = 1'b1;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                next_state = S_FETCH;
                cnt_inc    = 1'b1;
            end
            S_HALT:   next_state = S_HALT;
            S_FAULT:  next_state = S_FAULT;
            default:  next_state = S_IDLE;
        endcase
        // A stack fault pre-empts whatever the sequencer would have done, retire included.
        if (Overflow && state != S_IDLE && state != S_HALT) begin
            next_state = S_FAULT;
            cnt_inc    = 1'b0;
        end
    end

    always_comb begin
        PCWrite   = 1'b0;
        PCControl = PCC_INC;
        RStackOP  = RS_NOP;
        IRWrite   = 1'b0;
        Halted    = 1'b0;
        Fault     = 1'b0;
        case (state)
            S_FETCH: IRWrite = 1'b1;
            S_EXEC: begin
                PCWrite = 1'b1;
                case (op_class)
                    C_JUMP: PCControl = PCC_JUMP;
                    C_CALL: begin
                        PCControl = PCC_JUMP;
                        RStackOP  = RS_PUSH;
                    end
                    C_RET: begin
                        PCControl = PCC_RSTACK;
                        RStackOP  = RS_POP;
                    end
                    C_BZ:    PCControl = take ? PCC_BRANCH : PCC_INC;
                    default: PCControl = PCC_INC;
                endcase
            end
            S_HALT:  Halted = 1'b1;
            S_FAULT: Fault  = 1'b1;
            default: ;
        endcase
    end

    assign InstCount = count;

endmodule

// File: tb/tb_pc_sequencer_ctrl.sv
// Directed plus randomized bench for pc_sequencer_ctrl against a per-instruction
// reference table; a narrow counter keeps the wrap scenario short.
module tb_pc_sequencer_ctrl;

    localparam int unsigned CW = 8;

    logic          CLK = 1'b0;
    logic          Reset, Run, Zero, Overflow;
    logic [15:0]   inst;
    logic          PCWrite, IRWrite, Halted, Fault;
    logic [2:0]    PCControl;
    logic [1:0]    RStackOP;
    logic [CW-1:0] InstCount;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned exp_cnt  = 0;

    pc_sequencer_ctrl #(.CNT_W(CW)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Run       (Run),
        .inst      (inst),
        .Zero      (Zero),
        .Overflow  (Overflow),
        .PCWrite   (PCWrite),
        .PCControl (PCControl),
        .RStackOP  (RStackOP),
        .IRWrite   (IRWrite),
        .Halted    (Halted),
        .Fault     (Fault),
        .InstCount (InstCount)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected EXEC-cycle {PCWrite, PCControl, RStackOP} for an opcode and the Zero seen in DECODE.
    function automatic logic [5:0] exec_model(input logic [3:0] op, input logic z);
        case (op)
            4'h1:    return {1'b1, 3'd1, 2'd0};
            4'h2:    return {1'b1, 3'd1, 2'd1};
            4'h3:    return {1'b1, 3'd0, 2'd3};
            4'h4:    return {1'b1, (z ? 3'd2 : 3'd4), 2'd0};
            default: return {1'b1, 3'd4, 2'd0};
        endcase
    endfunction

    task automatic chk_idle_outs(input string tag, input logic irw);
        chk({tag, "_irw"}, IRWrite, irw);
        chk({tag, "_pcw"}, PCWrite, 1'b0);
        chk({tag, "_pcc"}, PCControl, 3'd4);
        chk({tag, "_rs"},  RStackOP, 2'd0);
    endtask

    task automatic chk_cnt(input string tag);
        chk(tag, InstCount, exp_cnt % (1 << CW));
    endtask

    // Called with the DUT in FETCH; leaves it in FETCH, or in HALT for opcode F.
    task automatic do_instr(input logic [15:0] ins, input logic z, input logic full);
        logic [5:0] e;
        inst = ins;
        if (full) chk_idle_outs("fetch", 1'b1);
        tick();
        Zero = z;
        if (full) chk_idle_outs("decode", 1'b0);
        tick();
        Zero = ~z;
        if (ins[15:12] == 4'hF) begin
            exp_cnt++;
            chk("halt_flag", Halted, 1'b1);
            chk_cnt("halt_cnt");
            return;
        end
        if (full) begin
            e = exec_model(ins[15:12], z);
            chk("exec_pcw", PCWrite, e[5]);
            chk("exec_pcc", PCControl, e[4:2]);
            chk("exec_rs",  RStackOP, e[1:0]);
            chk("exec_irw", IRWrite, 1'b0);
            chk_cnt("exec_cnt_before");
        end
        tick();
        exp_cnt++;
        if (full) chk_cnt("retire_cnt");
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        tick();
        exp_cnt = 0;
        Reset = 1'b1;
    endtask

    task automatic start();
        Run = 1'b1;
        tick();
        Run = 1'b0;
    endtask

    initial begin
        logic [3:0] op;
        Reset = 1'b0; Run = 1'b0; Zero = 1'b0; Overflow = 1'b0; inst = '0;
        tick();
        tick();
        chk_idle_outs("reset", 1'b0);
        chk("reset_halted", Halted, 1'b0);
        chk("reset_fault", Fault, 1'b0);
        chk_cnt("reset_cnt");
        Reset = 1'b1;

        // Idle until Run
        tick();
        chk("idle_wait_irw", IRWrite, 1'b0);

        start();
        do_instr(16'h0000, 1'b0, 1'b1);
        do_instr(16'h0000, 1'b0, 1'b1);
        do_instr(16'h0000, 1'b0, 1'b1);
        chk("seq_cnt3", InstCount, 3);

        do_instr(16'h2005, 1'b0, 1'b1);
        do_instr(16'h3000, 1'b1, 1'b1);
        do_instr(16'h4000, 1'b1, 1'b1);
        do_instr(16'h4000, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 14));
            do_instr({op, 12'($urandom)}, 1'($urandom), 1'b1);
        end

        // Halt is terminal and freezes the counter
        do_instr(16'hF000, 1'b0, 1'b1);
        Run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_hold", Halted, 1'b1);
            chk("halt_pcw", PCWrite, 1'b0);
            chk("halt_irw", IRWrite, 1'b0);
            chk_cnt("halt_cnt_frozen");
        end
        Run = 1'b0;
        do_reset();
        chk("halt_cleared", Halted, 1'b0);
        chk_cnt("halt_reset_cnt");

        // Overflow during DECODE
        start();
        do_instr(16'h0000, 1'b0, 1'b1);
        inst = 16'h2005;
        tick();
        Overflow = 1'b1;
        tick();
        Overflow = 1'b0;
        chk("ovf_fault", Fault, 1'b1);
        chk_idle_outs("ovf", 1'b0);
        chk_cnt("ovf_cnt");
        Run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fault_hold", Fault, 1'b1);
            chk("fault_irw", IRWrite, 1'b0);
        end
        Run = 1'b0;
        do_reset();
        chk("fault_cleared", Fault, 1'b0);

        // Overflow coinciding with an EXEC retire
        start();
        inst = 16'h0000;
        tick();
        tick();
        chk("exec_pre_pcw", PCWrite, 1'b1);
        Overflow = 1'b1;
        tick();
        Overflow = 1'b0;
        chk("exec_ovf_fault", Fault, 1'b1);
        chk_cnt("exec_ovf_cnt");
        do_reset();

        // Reset during DECODE of a CALL
        start();
        inst = 16'h2005;
        tick();
        Reset = 1'b0;
        Run = 1'b1;
        tick();
        exp_cnt = 0;
        chk_idle_outs("rst_mid", 1'b0);
        chk_cnt("rst_mid_cnt");
        Reset = 1'b1;
        Run = 1'b0;
        tick();
        chk("rst_mid_idle_rs", RStackOP, 2'd0);
        chk("rst_mid_idle_irw", IRWrite, 1'b0);

        // Counter wraps modulo 2^CW
        start();
        for (int i = 0; i < (1 << CW) - 1; i++)
            do_instr(16'h0000, 1'b0, 1'b0);
        chk("wrap_max", InstCount, (1 << CW) - 1);
        do_instr(16'h0000, 1'b0, 1'b1);
        chk("wrap_zero", InstCount, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer_ctrl.md
# pc_sequencer_ctrl

Multicycle control FSM for the stack processor's PC/return-stack datapath. It drives the datapath's `PCWrite`, `PCControl` and `RStackOP` inputs and consumes the fetched `inst`, the ALU `Zero` flag and the return-stack `Overflow`. It sequences fetch/decode/execute, resolves jump, call, return and conditional branch, and stops on halt or on a stack fault.

## Interface
Parameters:
- `CNT_W`, 16, width of the retired-instruction counter.

Ports:
- `CLK`  in  1  single clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-low reset; sampled on the `CLK` rising edge.
- `Run`  in  1  start request, sampled in IDLE.
- `inst`  in  16  instruction from instruction memory, addressed by the current PC.
- `Zero`  in  1  ALU zero flag, sampled in DECODE.
- `Overflow`  in  1  return-stack over/underflow indication.
- `PCWrite`  out  1  PC register load enable.
- `PCControl`  out  3  PC source select:
  - 0 = top of return stack
  - 1 = jump target
  - 2 = branch target
  - 4 = PC+2
- `RStackOP`  out  2  return-stack operation: 0 nop, 1 push PC+2, 3 pop; 2 is never driven.
- `IRWrite`  out  1  instruction-register capture strobe.
- `Halted`  out  1  HALT executed; sticky.
- `Fault`  out  1  stack overflow seen; sticky.
- `InstCount`  out  CNT_W  retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALT, FAULT.
- IDLE → FETCH when `Run`=1; otherwise stay in IDLE.
- FETCH: `IRWrite`=1 and the internal IR captures `inst`. Next state DECODE.
- DECODE: classify `IR[15:12]` and register `take = Zero` for BZ. Next state EXEC, or HALT for opcode 0xF.
- EXEC: drive the opcode's outputs for exactly one cycle, increment `InstCount`, next state FETCH.
- Opcodes and EXEC outputs:
  - 0x1 JUMP: `PCWrite`=1, `PCControl`=1.
  - 0x2 CALL: `PCWrite`=1, `PCControl`=1, `RStackOP`=1, all in the same cycle. The push captures the pre-update PC+2.
  - 0x3 RET: `PCWrite`=1, `PCControl`=0, `RStackOP`=3 in the same cycle.
  - 0x4 BZ: `PCWrite`=1, `PCControl` = 2 if `take`, else 4.
  - 0xF HALT: no EXEC cycle. Enters HALT with `Halted`=1, all other strobes 0, and `InstCount` incremented once on entry.
  - Any other opcode: `PCWrite`=1, `PCControl`=4.
- HALT and FAULT are terminal; only `Reset` leaves them.
- `Overflow`=1 in any state other than IDLE/HALT forces FAULT on the next edge. This overrides the normal transition, the `InstCount` increment is suppressed, and `Fault`=1.
- All outputs are Moore: decoded only from registered state, IR and `take`, never from live `inst`/`Zero`/`Overflow`.
- In non-EXEC states `PCWrite`=0 and `RStackOP`=0. `PCControl` is 4 except in EXEC.
- `InstCount` wraps modulo 2^CNT_W.

## Timing
- Reset (`Reset`=0 at an edge), taking effect on that edge:
  - state IDLE, IR 0, `take` 0, `InstCount` 0;
  - `PCWrite`/`RStackOP`/`IRWrite`/`Halted`/`Fault` 0, `PCControl` 4.
  - This holds mid-instruction and in HALT/FAULT.
- Each non-halt instruction takes 3 cycles: FETCH, DECODE, EXEC. The PC updates on the EXEC edge, and the next FETCH sees the new `inst`.
- First FETCH occurs the cycle after `Run` is sampled high. `Run` is ignored outside IDLE.
- `Overflow` and an EXEC increment on the same edge: FAULT wins and the count is not incremented.
- `Run`=1 while `Reset`=0: reset wins.

## Structure
- Package `pc_seq_pkg` holds:
  - opcode constants;
  - `PCControl` encodings (0/1/2/4) and `RStackOP` encodings (0/1/3);
  - the state enum.
- Sub-module `pc_seq_decode`: combinational IR[15:12] → opcode class (SEQ/JUMP/CALL/RET/BZ/HALT). The FSM, IR, `take` and counter stay in the top.

## Test plan
- Reset, `Run` pulse, `inst`=0x0000 held: `IRWrite` high every 3rd cycle; `PCWrite`=1, `PCControl`=4 in EXEC only; `InstCount` 1, 2, 3 after 3, 6, 9 cycles.
- `inst`=0x2005 then 0x3000: CALL EXEC shows `PCWrite`=1, `PCControl`=1, `RStackOP`=1. RET EXEC shows `PCWrite`=1, `PCControl`=0, `RStackOP`=3.
- `inst`=0x4000 with `Zero`=1 in DECODE → EXEC `PCControl`=2. Repeat with `Zero`=0 → 4. `Zero` toggled during EXEC has no effect.
- `inst`=0xF000: after DECODE `Halted`=1 and stays 1 for 10 cycles with `PCWrite`=0 and `InstCount` frozen. `Reset`=0 clears it to IDLE.
- `Overflow`=1 during DECODE → next cycle `Fault`=1, outputs idle, `InstCount` unchanged. `Run` is then ignored until reset.
- `Reset`=0 asserted in DECODE of a CALL: next cycle all outputs at reset values and no push is issued. Preload `InstCount` near 0xFFFF by running 65535 SEQ instructions; the next retire wraps it to 0.
